display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
- Shares one 4-digit seven-segment display between NUM_REQ independent value sources, such as the score, debug and status producers.
- Grants display ownership round-robin.
- Guarantees each owner a minimum visible dwell time, and inserts a blank gap between owners so digits never smear.
- Sits in front of seven_segment_controller: disp_value drives its binary input, and disp_blank gates its anode enables off.

Parameters:
- NUM_REQ, 4, number of requesters (2..4).
- DWELL_CYCLES, 1000000, minimum clk cycles an owner is shown before it can be preempted (≥2, fits 20 bits).
- GAP_CYCLES, 1000, blank cycles between owners (≥1, fits 20 bits).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-low reset; sampled only on the rising edge of clk, 0 = reset.
- req  in  NUM_REQ  level request per source; held high while the source wants the display.
- value_flat  in  8*NUM_REQ  signed 8-bit value per source; source i occupies bits [8i+7:8i].
- grant  out  NUM_REQ  one-hot owner, or all-zero; registered.
- owner  out  2  index of current/last owner; registered.
- disp_value  out  8  signed value to display; registered.
- disp_blank  out  1  1 = display must be dark; registered.
- switch_pulse  out  1  one-cycle pulse on each new ownership start.

Behaviour:
- Reset (rst=0 at an edge), applied at any time including mid-SHOW or mid-GAP:
  - state=IDLE, grant=0, owner=0, disp_value=0, disp_blank=1, switch_pulse=0.
  - Round-robin pointer ptr=0, count=0.
- States are IDLE, SHOW and GAP.
- Arbitration (combinational pick):
  - Search req starting at index ptr, ascending with wrap mod NUM_REQ.
  - The first set bit wins.
  - ptr becomes winner+1 mod NUM_REQ when a grant is issued.
- IDLE:
  - Hold disp_blank=1, grant=0.
  - If any req is sampled high at edge N: at edge N the state becomes SHOW with the following registered values:
    - grant set to the winner;
    - owner set to the winner index;
    - disp_blank=0;
    - disp_value set to the winner's value;
    - count=0;
    - switch_pulse=1 for that one cycle.
  - Latency from req to visible grant: 1 cycle.
- SHOW:
  - Every edge, disp_value reloads from the owner's value slice, so live value changes appear with 1-cycle latency.
  - count increments, saturating at DWELL_CYCLES-1.
  - Owner req low at an edge: leave SHOW immediately, regardless of count. Go to GAP with grant=0 and disp_blank=1.
  - count==DWELL_CYCLES-1 and another req pending: go to GAP, same outputs.
  - count==DWELL_CYCLES-1 and no other req pending: stay in SHOW indefinitely with the count saturated. A later foreign req preempts at the next edge.
  - Owner drop and dwell expiry in the same cycle: treated as an owner drop; the result is identical (GAP).
- GAP:
  - disp_blank=1, grant=0, disp_value holds its last value.
  - count restarts at 0 on entry and runs to GAP_CYCLES-1.
  - At the final GAP edge, arbitrate using the req sampled at that edge:
    - winner present: go to SHOW as from IDLE (switch_pulse=1);
    - none: go to IDLE.
  - Requests that rise and fall entirely within GAP are not remembered.
- Winner rules:
  - The previous owner is eligible again only after all others (ptr ordering).
  - If it is the sole requester it regains ownership after the gap.
- Invariants:
  - grant is one-hot or zero.
  - grant!=0 if and only if disp_blank==0.
  - switch_pulse is never high in two consecutive cycles.
- Value slices not owned are ignored; X on them must not propagate.

Decomposition:
- Shared package display_pkg holds:
  - the state encoding constants ST_IDLE, ST_SHOW, ST_GAP (2 bits);
  - COUNT_W=20;
  - VALUE_W=8.
- One sub-module, rr_picker: combinational round-robin selector.
  - Inputs: req and ptr.
  - Outputs: found and winner index.
- The top holds the FSM, the counter and the output registers.

Test Plan (DWELL_CYCLES=8, GAP_CYCLES=2, NUM_REQ=4):
- Reset/idle: hold rst=0 for 3 edges, then release with req=0.
  - Required: grant=0000, disp_blank=1, disp_value=0, switch_pulse=0 throughout.
- Single requester: req=0010 with value1=-42 at edge N.
  - Required: after edge N, grant=0010, owner=1, disp_value=0xD6, disp_blank=0, switch_pulse high for one cycle.
  - Change value1 to 17: disp_value=0x11 one cycle later.
  - Ownership is held indefinitely while no other req is pending.
- Contention round-robin: req=1011 continuously.
  - Required grant sequence: 0001, then 0010, then 1000, then 0001.
  - Each grant lasts exactly 8 cycles.
  - Each grant is separated by exactly 2 disp_blank cycles.
- Early release: owner 0 drops req at count=3 while req2 is high.
  - Required: the next edge gives grant=0 and disp_blank=1; after 2 cycles grant=0100.
- Simultaneous drop and expiry: owner drops on the same cycle count reaches 7.
  - Required: a single entry to GAP; no double switch_pulse.
- Reset mid-SHOW: assert rst=0 while grant=0100.
  - Required: at the next edge, all outputs are at their reset values and ptr=0.
  - After release with req=0101, grant=0001.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and state encoding for the display arbiter.
// Imported by the arbiter top and its round-robin picker.
package display_pkg;

    localparam int COUNT_W = 20;
    localparam int VALUE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
// Scans req from ptr upward with wrap; the first set bit wins.
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic               found,
    output logic [1:0]         winner
);

    logic [2:0] sum;
    logic [1:0] idx;

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        sum    = 3'd0;
        idx    = 2'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + 3'(i);
            if (sum >= 3'(NUM_REQ)) begin
                sum = sum - 3'(NUM_REQ);
            end
            idx = sum[1:0];
            if (req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of a shared 4-digit seven-segment display.
// Enforces a minimum dwell per owner and a dark gap between owners.
module display_arbiter
    import display_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 1000000,
    parameter int GAP_CYCLES   = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [VALUE_W*NUM_REQ-1:0] value_flat,
    output logic [NUM_REQ-1:0]         grant,
    output logic [1:0]                 owner,
    output logic [VALUE_W-1:0]         disp_value,
    output logic                       disp_blank,
    output logic                       switch_pulse
);

    localparam logic [COUNT_W-1:0] DWELL_LAST = COUNT_W'(DWELL_CYCLES - 1);
    localparam logic [COUNT_W-1:0] GAP_LAST   = COUNT_W'(GAP_CYCLES - 1);

    state_t               state;
    state_t               state_n;
    logic [COUNT_W-1:0]   count;
    logic [COUNT_W-1:0]   count_n;
    logic [1:0]           ptr;
    logic [1:0]           ptr_n;
    logic [NUM_REQ-1:0]   grant_n;
    logic [1:0]           owner_n;
    logic [VALUE_W-1:0]   value_n;
    logic                 blank_n;
    logic                 pulse_n;
    logic                 launch;

    logic                 found;
    logic [1:0]           winner;
    logic [NUM_REQ-1:0]   winner_grant;
    logic [VALUE_W-1:0]   winner_value;
    logic [VALUE_W-1:0]   owner_value;
    logic [1:0]           ptr_adv;
    logic                 owner_req;
    logic                 others;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

    assign winner_grant = NUM_REQ'(1) << winner;
    assign winner_value = value_flat[int'(winner)*VALUE_W +: VALUE_W];
    assign owner_value  = value_flat[int'(owner)*VALUE_W +: VALUE_W];
    assign ptr_adv      = (winner == 2'(NUM_REQ - 1)) ? 2'd0 : winner + 2'd1;
    assign owner_req    = req[owner];
    assign others       = |(req & ~grant);

    // Next-state and next-output logic; launch starts a new ownership.
    always_comb begin
        state_n = state;
        count_n = count;
        ptr_n   = ptr;
        grant_n = grant;
        owner_n = owner;
        value_n = disp_value;
        blank_n = disp_blank;
        pulse_n = 1'b0;
        launch  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                grant_n = '0;
                blank_n = 1'b1;
                launch  = found;
            end
            ST_SHOW: begin
                value_n = owner_value;
                if (!owner_req || (count == DWELL_LAST && others)) begin
                    state_n = ST_GAP;
                    grant_n = '0;
                    blank_n = 1'b1;
                    count_n = '0;
                end else if (count != DWELL_LAST) begin
                    count_n = count + 1'b1;
                end
            end
            ST_GAP: begin
                grant_n = '0;
                blank_n = 1'b1;
                if (count == GAP_LAST) begin
                    count_n = '0;
                    if (found) begin
                        launch = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    count_n = count + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
                blank_n = 1'b1;
                count_n = '0;
            end
        endcase
        if (launch) begin
            state_n = ST_SHOW;
            grant_n = winner_grant;
            owner_n = winner;
            value_n = winner_value;
            blank_n = 1'b0;
            count_n = '0;
            pulse_n = 1'b1;
            ptr_n   = ptr_adv;
        end
    end

    // State, counter, pointer and registered outputs with sync reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            count        <= '0;
            ptr          <= 2'd0;
            grant        <= '0;
            owner        <= 2'd0;
            disp_value   <= '0;
            disp_blank   <= 1'b1;
            switch_pulse <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            ptr          <= ptr_n;
            grant        <= grant_n;
            owner        <= owner_n;
            disp_value   <= value_n;
            disp_blank   <= blank_n;
            switch_pulse <= pulse_n;
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with DWELL=8, GAP=2, NUM_REQ=4.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_display_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] value_flat;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic [7:0]  disp_value;
    logic        disp_blank;
    logic        switch_pulse;

    int total;
    int passed;
    int failed;
    logic prev_pulse;

    display_arbiter #(
        .NUM_REQ      (4),
        .DWELL_CYCLES (8),
        .GAP_CYCLES   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .value_flat   (value_flat),
        .grant        (grant),
        .owner        (owner),
        .disp_value   (disp_value),
        .disp_blank   (disp_blank),
        .switch_pulse (switch_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check the invariants.
    task automatic tick();
        @(negedge clk);
        chk("inv_onehot", 32'($countones(grant) <= 1), 32'd1);
        chk("inv_blank", 32'((grant != 4'd0) ^ disp_blank), 32'd1);
        chk("inv_pulse2", 32'(prev_pulse & switch_pulse), 32'd0);
        prev_pulse = switch_pulse;
    endtask

    task automatic expect_run(input string tag, input logic [3:0] g,
                              input int n, input logic [7:0] v,
                              input logic p);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_grant"}, 32'(grant), 32'(g));
            chk({tag, "_blank"}, 32'(disp_blank), 32'(g == 4'd0));
            chk({tag, "_value"}, 32'(disp_value), 32'(v));
            chk({tag, "_pulse"}, 32'(switch_pulse), 32'(p && i == 0));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_owner"}, 32'(owner), 32'd0);
        chk({tag, "_value"}, 32'(disp_value), 32'd0);
        chk({tag, "_blank"}, 32'(disp_blank), 32'd1);
        chk({tag, "_pulse"}, 32'(switch_pulse), 32'd0);
    endtask

    initial begin
        total      = 0;
        passed     = 0;
        failed     = 0;
        prev_pulse = 1'b0;
        rst        = 1'b0;
        req        = 4'b0000;
        value_flat = 32'd0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk_reset("rst_hold");
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_reset("idle");
        end

        value_flat[15:8]  = 8'hD6;
        value_flat[31:24] = 8'hxx;
        req = 4'b0010;
        tick();
        chk("single_grant", 32'(grant), 32'h2);
        chk("single_owner", 32'(owner), 32'd1);
        chk("single_value", 32'(disp_value), 32'hD6);
        chk("single_blank", 32'(disp_blank), 32'd0);
        chk("single_pulse", 32'(switch_pulse), 32'd1);
        value_flat[15:8] = 8'h11;
        tick();
        chk("live_value", 32'(disp_value), 32'h11);
        chk("live_pulse", 32'(switch_pulse), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("hold_grant", 32'(grant), 32'h2);
        chk("hold_value", 32'(disp_value), 32'h11);

        rst = 1'b0;
        req = 4'b0000;
        tick();
        chk_reset("rst_show");

        value_flat = {8'h83, 8'h22, 8'hF1, 8'h10};
        rst = 1'b1;
        req = 4'b1011;
        expect_run("rr0", 4'b0001, 8, 8'h10, 1'b1);
        expect_run("rr_gap1", 4'b0000, 2, 8'h10, 1'b0);
        expect_run("rr1", 4'b0010, 8, 8'hF1, 1'b1);
        expect_run("rr_gap2", 4'b0000, 2, 8'hF1, 1'b0);
        expect_run("rr3", 4'b1000, 8, 8'h83, 1'b1);
        expect_run("rr_gap3", 4'b0000, 2, 8'h83, 1'b0);
        expect_run("rr0b", 4'b0001, 1, 8'h10, 1'b1);

        req = 4'b0101;
        expect_run("er_hold", 4'b0001, 3, 8'h10, 1'b0);
        req = 4'b0100;
        expect_run("er_gap", 4'b0000, 2, 8'h10, 1'b0);
        expect_run("er_own2", 4'b0100, 1, 8'h22, 1'b1);

        req = 4'b0101;
        expect_run("se_hold", 4'b0100, 7, 8'h22, 1'b0);
        req = 4'b0001;
        expect_run("se_gap", 4'b0000, 2, 8'h22, 1'b0);
        expect_run("se_own0", 4'b0001, 2, 8'h10, 1'b1);

        req = 4'b0100;
        expect_run("rm_gap", 4'b0000, 2, 8'h10, 1'b0);
        expect_run("rm_own2", 4'b0100, 2, 8'h22, 1'b1);
        rst = 1'b0;
        req = 4'b0101;
        tick();
        chk_reset("rst_mid");
        rst = 1'b1;
        expect_run("rm_after", 4'b0001, 1, 8'h10, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
